det_rr_sched: RTL

- Round-robin scheduler that shares one overlapping Mealy "three consecutive 1s" detector among N serial requesters.
- Each requester asks for the detector, streams a burst of bits under valid/last handshaking, and receives a per-burst hit count on completion.
- Detector state is cleared at each burst start, so bursts never interact.
- Sits between N serial bit sources and the single detector core.

---
 rtl/det_sched_pkg.sv | 21 ++
 rtl/ones_det_core.sv | 39 +++
 rtl/det_rr_sched.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/det_sched_pkg.sv
// Shared types and helpers for the round-robin three-ones detector scheduler.
package det_sched_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } sched_st_t;

   typedef enum logic [1:0] {
      S0 = 2'd0,
      S1 = 2'd1,
      S2 = 2'd2
   } det_st_t;

   // Channel index width; never below one bit.
   function automatic int unsigned chw(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ones_det_core.sv
// Overlapping Mealy detector for three consecutive 1s; state counts trailing 1s.
module ones_det_core
   import det_sched_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic vld,
   input  logic x,
   output logic z
);

   det_st_t st, st_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) st <= S0;
      else     st <= st_nxt;
   end

   always_comb begin
      st_nxt = st;
      z      = 1'b0;
      if (clr) begin
         st_nxt = S0;
      end else if (vld) begin
         z = x && (st == S2);
         if (!x) begin
            st_nxt = S0;
         end else begin
            case (st)
               S0:      st_nxt = S1;
               S1:      st_nxt = S2;
               default: st_nxt = S2;
            endcase
         end
      end
   end

endmodule

// File: rtl/det_rr_sched.sv
// Round-robin scheduler sharing one three-ones detector among N serial requesters.
// Optional idle timeout in STREAM enabled by defining SCHED_TIMEOUT_EN.
module det_rr_sched
   import det_sched_pkg::*;
#(
   parameter int unsigned N   = 4,
   parameter int unsigned CW  = 8,
   parameter int unsigned TMO = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N-1:0]            req,
   input  logic [N-1:0]            bit_in,
   input  logic [N-1:0]            bit_vld,
   input  logic [N-1:0]            bit_last,
   output logic [N-1:0]            gnt,
   output logic                    z,
   output logic                    busy,
   output logic                    done,
   output logic [chw(N)-1:0]       done_ch,
   output logic [CW-1:0]           hit_cnt,
   output logic                    abort
);

   localparam int unsigned CHW = chw(N);
   localparam int unsigned SW  = CHW + 1;

   sched_st_t      st, st_nxt;
   logic [CHW-1:0] ch, ptr, pick;
   logic           pick_vld;
   logic [SW-1:0]  rr_idx;
   logic [CW-1:0]  cnt, cnt_nxt;
   logic           acc, abort_nxt, det_z;

   assign acc = (st == STREAM) && req[ch] && bit_vld[ch];
   assign z   = det_z;

   ones_det_core u_core (
      .clk (clk),
      .rst (rst),
      .clr (st == IDLE),
      .vld (acc),
      .x   (bit_in[ch]),
      .z   (det_z)
   );

`ifdef SCHED_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TMO + 1);
   logic [TW-1:0] tmo_cnt;
   logic          tmo_hit;

   assign tmo_hit = !acc && (tmo_cnt == TW'(TMO - 1));

   // Counts consecutive STREAM cycles without an accepted bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                       tmo_cnt <= '0;
      else if (st != STREAM || acc)  tmo_cnt <= '0;
      else                           tmo_cnt <= tmo_cnt + TW'(1);
   end
`endif

   // First requester at or after the pointer, wrapping.
   always_comb begin
      pick     = '0;
      pick_vld = 1'b0;
      rr_idx   = '0;
      for (int unsigned i = 0; i < N; i++) begin
         rr_idx = {1'b0, ptr} + SW'(i);
         if (rr_idx >= SW'(N)) rr_idx = rr_idx - SW'(N);
         if (!pick_vld && req[rr_idx[CHW-1:0]]) begin
            pick     = rr_idx[CHW-1:0];
            pick_vld = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) st <= IDLE;
      else     st <= st_nxt;
   end

   always_comb begin
      st_nxt    = st;
      abort_nxt = 1'b0;
      cnt_nxt   = cnt;
      if (det_z && (cnt != '1)) cnt_nxt = cnt + CW'(1);
      case (st)
         IDLE: begin
            if (pick_vld) st_nxt = STREAM;
         end
         STREAM: begin
            if (!req[ch]) begin
               st_nxt    = DONE;
               abort_nxt = 1'b1;
            end else if (acc && bit_last[ch]) begin
               st_nxt = DONE;
`ifdef SCHED_TIMEOUT_EN
            end else if (tmo_hit) begin
               st_nxt    = DONE;
               abort_nxt = 1'b1;
`endif
            end
         end
         DONE:    st_nxt = IDLE;
         default: st_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt     <= '0;
         ch      <= '0;
         ptr     <= '0;
         cnt     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         done_ch <= '0;
         hit_cnt <= '0;
         abort   <= 1'b0;
      end else begin
         busy    <= (st_nxt != IDLE);
         done    <= 1'b0;
         done_ch <= '0;
         hit_cnt <= '0;
         abort   <= 1'b0;
         cnt     <= (st == IDLE) ? '0 : cnt_nxt;
         if (st == IDLE && pick_vld) begin
            gnt <= N'(1) << pick;
            ch  <= pick;
         end
         if (st == STREAM && st_nxt == DONE) begin
            gnt     <= '0;
            done    <= 1'b1;
            done_ch <= ch;
            hit_cnt <= cnt_nxt;
            abort   <= abort_nxt;
         end
         if (st == DONE) ptr <= (ch == CHW'(N - 1)) ? '0 : ch + CHW'(1);
      end
   end

endmodule
